arbiter_puf_ctrl: RTL and testbench
===================================

Name: arbiter_puf_ctrl

Overview:
Parametrised evaluation controller for the delay-chain arbiter PUF, replacing the free-running counter-plus-arbiter top. On a start request it sweeps a contiguous range of challenges from a seed. It evaluates the external PUF core NUM_EVAL times per challenge, majority-votes each response bit, packs the results into a RESP_BITS-wide word, counts unstable bits, and drives the two board LEDs from the last voted bit.

Parameters:
CH_W, 8, challenge width in bits (PUF stage count)
RESP_BITS, 16, number of response bits collected per run (1..256)
NUM_EVAL, 5, evaluations per challenge; must be odd, range 1..15
SETTLE_CYC, 4, clk cycles between launch and sampling of the arbiter output (1..255)

Ports:
clk  in  1  single system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets, release synchronous to clk)
start  in  1  one-cycle request to begin a run; sampled only in IDLE
seed  in  CH_W  first challenge of the run; captured with start
busy  out  1  high from cycle after accepted start until DONE exits
done  out  1  one-cycle pulse when resp_word/unstable_cnt are valid
puf_ch  out  CH_W  challenge driven to PUF mux selects
puf_clr  out  1  arbiter latch clear to PUF core
puf_launch  out  1  launch edge into both delay paths
puf_resp  in  1  arbiter latch output, already synchronised by PUF core
resp_word  out  RESP_BITS  voted response; bit k belongs to challenge seed+k
unstable_cnt  out  clog2(RESP_BITS+1)  bits whose votes were not unanimous
led1  out  1  1 when last voted bit = 0
led2  out  1  1 when last voted bit = 1

Behaviour:
- Reset (rst=0, any state, any time): state=IDLE. busy=0, done=0, puf_clr=0, puf_launch=0, puf_ch=0, resp_word=0, unstable_cnt=0, led1=1, led2=0. Vote, eval and bit counters are cleared. A run in progress is abandoned and no done is issued.
- FSM states: IDLE, CLEAR, LAUNCH, SETTLE, SAMPLE, STORE, DONE.
- IDLE: when start=1, capture seed into the challenge register, clear resp_word, unstable_cnt and all counters, and go to CLEAR. start is ignored in every other state.
- CLEAR (1 cycle): puf_clr=1, puf_launch=0. Next state is LAUNCH.
- LAUNCH (1 cycle): puf_launch=1. Next state is SETTLE with the settle counter loaded.
- SETTLE (SETTLE_CYC cycles): puf_launch stays 1. Next state is SAMPLE.
- SAMPLE (1 cycle): puf_launch=1. At the end of the cycle, add puf_resp to the ones-count. If the eval counter < NUM_EVAL-1, increment it and go to CLEAR; otherwise go to STORE.
- STORE (1 cycle):
  - Voted bit = (ones > NUM_EVAL/2), written to resp_word[bit_idx].
  - If ones is not 0 and not NUM_EVAL, increment unstable_cnt.
  - led1/led2 update from the voted bit.
  - Clear ones and the eval counter.
  - If bit_idx = RESP_BITS-1 go to DONE. Otherwise increment bit_idx and the challenge, then go to CLEAR.
- Challenge increment is modulo 2^CH_W: 0xFF+1 wraps to 0x00 with no flag.
- DONE (1 cycle): done=1, busy=0 on the following cycle, return to IDLE. resp_word, unstable_cnt and the LEDs hold until the next accepted start or reset. puf_ch holds its last challenge.
- puf_ch is stable from CLEAR through SAMPLE of every evaluation and changes only on exit from STORE.
- Latency: each evaluation takes 3+SETTLE_CYC cycles, and each bit takes NUM_EVAL*(3+SETTLE_CYC)+1. For a start sampled at edge T, done is high in the cycle after edge T+RESP_BITS*(NUM_EVAL*(3+SETTLE_CYC)+1). With defaults this is 16*36 = 576 edges.
- busy=1 in the cycle after start is sampled and stays 1 through DONE. start asserted in the DONE cycle is ignored.
- Ones-counter width is clog2(NUM_EVAL+1). It cannot overflow because the count is bounded by NUM_EVAL.

Test Plan:
- Reset mid-run: assert rst=0 during SETTLE of bit 3 -> busy, done, puf_launch and puf_clr go to 0 immediately; no done follows; a new start runs a full-length sweep.
- Ideal PUF (puf_resp = parity of puf_ch), defaults, seed=0x10 -> done 576 cycles after start; resp_word[k] = parity(0x10+k); unstable_cnt=0; led1/led2 match parity(0x1F).
- Wrap-around: seed=0xF8, RESP_BITS=16 -> puf_ch steps 0xF8..0xFF then 0x00..0x07, with no glitch on puf_ch between CLEAR and SAMPLE.
- Noisy PUF, NUM_EVAL=5: model returns 1 on 3 of 5 evals for bit 2 and on 2 of 5 for bit 5, all other bits unanimous 0 -> resp_word[2]=1, resp_word[5]=0, unstable_cnt=2.
- Handshake: pulse start every cycle during a run and in the DONE cycle -> exactly one done per accepted start; seed changes while busy have no effect.
- NUM_EVAL=1, SETTLE_CYC=1, RESP_BITS=4 -> done 20 edges after start; each challenge shows exactly one puf_clr and one puf_launch pulse train; unstable_cnt=0.

Source files
------------

// File: rtl/arbiter_puf_ctrl.sv
// arbiter_puf_ctrl: sweeps a challenge range, majority-votes NUM_EVAL PUF evaluations per challenge,
// packs the voted bits into resp_word and counts bits whose votes disagreed.
module arbiter_puf_ctrl #(
    parameter int CH_W       = 8,
    parameter int RESP_BITS  = 16,
    parameter int NUM_EVAL   = 5,
    parameter int SETTLE_CYC = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [CH_W-1:0]                seed,
    output logic                           busy,
    output logic                           done,
    output logic [CH_W-1:0]                puf_ch,
    output logic                           puf_clr,
    output logic                           puf_launch,
    input  logic                           puf_resp,
    output logic [RESP_BITS-1:0]           resp_word,
    output logic [$clog2(RESP_BITS+1)-1:0] unstable_cnt,
    output logic                           led1,
    output logic                           led2
);
    localparam int OW = $clog2(NUM_EVAL + 1);
    localparam int BW = $clog2(RESP_BITS + 1);
    localparam logic [OW-1:0] HALF   = OW'(NUM_EVAL / 2);
    localparam logic [OW-1:0] NE     = OW'(NUM_EVAL);
    localparam logic [3:0]    NE_M1  = 4'(NUM_EVAL - 1);
    localparam logic [BW-1:0] LAST   = BW'(RESP_BITS - 1);
    localparam logic [7:0]    SET_M1 = 8'(SETTLE_CYC - 1);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] LAUNCH = 3'd2;
    localparam logic [2:0] SETTLE = 3'd3;
    localparam logic [2:0] SAMPLE = 3'd4;
    localparam logic [2:0] STORE  = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    logic [2:0]           state_q, state_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [RESP_BITS-1:0] resp_q, resp_d;
    logic [BW-1:0]        unst_q, unst_d;
    logic [BW-1:0]        idx_q, idx_d;
    logic [OW-1:0]        ones_q, ones_d;
    logic [3:0]           eval_q, eval_d;
    logic [7:0]           settle_q, settle_d;
    logic                 led_q, led_d;
    logic                 vote;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        resp_d   = resp_q;
        unst_d   = unst_q;
        idx_d    = idx_q;
        ones_d   = ones_q;
        eval_d   = eval_q;
        settle_d = settle_q;
        led_d    = led_q;
        vote     = ones_q > HALF;
        case (state_q)
            IDLE: if (start) begin
                state_d = CLEAR;
                ch_d    = seed;
                resp_d  = '0;
                unst_d  = '0;
                idx_d   = '0;
                ones_d  = '0;
                eval_d  = '0;
            end
            CLEAR: state_d = LAUNCH;
            LAUNCH: begin
                state_d  = SETTLE;
                settle_d = SET_M1;
            end
            SETTLE: begin
                settle_d = settle_q - 8'd1;
                state_d  = (settle_q == 8'd0) ? SAMPLE : SETTLE;
            end
            SAMPLE: begin
                ones_d  = ones_q + OW'(puf_resp);
                state_d = (eval_q < NE_M1) ? CLEAR : STORE;
                eval_d  = (eval_q < NE_M1) ? eval_q + 4'd1 : eval_q;
            end
            STORE: begin
                resp_d  = resp_q | (RESP_BITS'(vote) << idx_q);
                unst_d  = (ones_q != '0 && ones_q != NE) ? unst_q + BW'(1) : unst_q;
                led_d   = vote;
                ones_d  = '0;
                eval_d  = '0;
                state_d = (idx_q == LAST) ? DONE : CLEAR;
                // challenge advances only on leaving STORE, keeping puf_ch stable across every evaluation
                idx_d   = (idx_q == LAST) ? idx_q : idx_q + BW'(1);
                ch_d    = (idx_q == LAST) ? ch_q : ch_q + CH_W'(1);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            resp_q   <= '0;
            unst_q   <= '0;
            idx_q    <= '0;
            ones_q   <= '0;
            eval_q   <= '0;
            settle_q <= '0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            resp_q   <= resp_d;
            unst_q   <= unst_d;
            idx_q    <= idx_d;
            ones_q   <= ones_d;
            eval_q   <= eval_d;
            settle_q <= settle_d;
            led_q    <= led_d;
        end
    end

    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign puf_clr      = state_q == CLEAR;
    assign puf_launch   = state_q == LAUNCH || state_q == SETTLE || state_q == SAMPLE;
    assign puf_ch       = ch_q;
    assign resp_word    = resp_q;
    assign unstable_cnt = unst_q;
    assign led1         = ~led_q;
    assign led2         = led_q;
endmodule

// File: tb/tb_arbiter_puf_ctrl.sv
// tb_arbiter_puf_ctrl: drives a weighted PUF model (ones-per-challenge table) and checks
// voted words, unstable counts, latency, challenge stability and handshake against a reference.
module tb_arbiter_puf_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] seed = 8'd0;
    logic       busy, done, puf_clr, puf_launch, puf_resp, led1, led2;
    logic [7:0] puf_ch;
    logic [15:0] resp_word;
    logic [4:0] unstable_cnt;

    logic       start2 = 1'b0;
    logic [7:0] seed2 = 8'd0;
    logic       busy2, done2, puf_clr2, puf_launch2, led1_2, led2_2;
    logic [7:0] puf_ch2;
    logic [3:0] resp_word2;
    logic [2:0] unstable_cnt2;

    int checks = 0, failures = 0;
    int w[256];
    int clr_tot = 0, base = 0, glitch = 0, done_tot = 0, clr2_tot = 0, launch2_tot = 0;
    logic [7:0] cur_seed = 8'd0;
    bit mon_on = 1'b0;

    typedef struct { logic [7:0] seed; int mode; bit spam; int exp_lat; } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    arbiter_puf_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .busy(busy), .done(done),
        .puf_ch(puf_ch), .puf_clr(puf_clr), .puf_launch(puf_launch), .puf_resp(puf_resp),
        .resp_word(resp_word), .unstable_cnt(unstable_cnt), .led1(led1), .led2(led2)
    );

    arbiter_puf_ctrl #(.CH_W(8), .RESP_BITS(4), .NUM_EVAL(1), .SETTLE_CYC(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .seed(seed2), .busy(busy2), .done(done2),
        .puf_ch(puf_ch2), .puf_clr(puf_clr2), .puf_launch(puf_launch2), .puf_resp(^puf_ch2),
        .resp_word(resp_word2), .unstable_cnt(unstable_cnt2), .led1(led1_2), .led2(led2_2)
    );

    // evaluation j of the current challenge answers 1 while j < w[challenge]
    assign puf_resp = (((clr_tot - base - 1) % 5) < w[puf_ch]);

    always @(posedge clk) begin
        if (puf_clr) clr_tot <= clr_tot + 1;
        if (done) done_tot <= done_tot + 1;
        if (puf_clr2) clr2_tot <= clr2_tot + 1;
        if (puf_launch2) launch2_tot <= launch2_tot + 1;
    end

    always @(negedge clk) begin
        if (mon_on && (puf_clr || puf_launch)) begin
            int k;
            k = (clr_tot - base - (puf_clr ? 0 : 1)) / 5;
            if (puf_ch !== 8'(cur_seed + k)) glitch <= glitch + 1;
        end
    end

    task automatic chk(input string run, input string what, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s got=%0d want=%0d", run, what, act, exp);
        end
    endtask

    task automatic set_w(input int mode, input logic [7:0] sd);
        for (int c = 0; c < 256; c++) begin
            case (mode)
                0: w[c] = ($countones(8'(c)) % 2) ? 5 : 0;
                1: w[c] = 0;
                2: w[c] = $urandom_range(0, 5);
                default: w[c] = $urandom_range(0, 1) * 5;
            endcase
        end
        if (mode == 1) begin
            w[8'(sd + 2)] = 3;
            w[8'(sd + 5)] = 2;
        end
    endtask

    task automatic run_check(input string nm, input logic [7:0] sd, input bit spam, input int exp_lat);
        logic [15:0] er, rw;
        logic [4:0] uc;
        logic l1, l2;
        logic [7:0] pc;
        int eu, lat, g0, d0;
        eu = 0;
        er = '0;
        for (int k = 0; k < 16; k++) begin
            er[k] = (w[8'(sd + k)] > 2);
            if (w[8'(sd + k)] != 0 && w[8'(sd + k)] != 5) eu++;
        end
        g0 = glitch;
        d0 = done_tot;
        @(negedge clk);
        seed = sd; cur_seed = sd; base = clr_tot; start = 1'b1; mon_on = 1'b1;
        @(negedge clk);
        lat = 0;
        start = spam;
        chk(nm, "busy_rise", busy, 1);
        while (done !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
            if (spam) seed = 8'($urandom);
        end
        rw = resp_word; uc = unstable_cnt; l1 = led1; l2 = led2; pc = puf_ch;
        @(negedge clk);
        start = 1'b0;
        mon_on = 1'b0;
        chk(nm, "latency", lat, exp_lat);
        chk(nm, "resp_word", rw, er);
        chk(nm, "unstable", uc, eu);
        chk(nm, "led1", l1, !er[15]);
        chk(nm, "led2", l2, er[15]);
        chk(nm, "last_ch", pc, 8'(sd + 15));
        chk(nm, "ch_stable", glitch - g0, 0);
        chk(nm, "busy_after", busy, 0);
        chk(nm, "done_count", done_tot - d0, 1);
        chk(nm, "resp_hold", resp_word, er);
    endtask

    initial begin
        logic [3:0] er2;
        int n, c0, l0, d0;
        vecs[0] = '{8'h10, 0, 1'b0, 576};
        vecs[1] = '{8'hF8, 0, 1'b0, 576};
        vecs[2] = '{8'h40, 1, 1'b0, 576};
        vecs[3] = '{8'h00, 2, 1'b0, 576};
        vecs[4] = '{8'hA5, 2, 1'b1, 576};
        vecs[5] = '{8'hFF, 3, 1'b0, 576};
        set_w(0, 8'h00);
        repeat (3) @(negedge clk);
        chk("reset", "busy", busy, 0);
        chk("reset", "done", done, 0);
        chk("reset", "clr_launch", {puf_clr, puf_launch}, 0);
        chk("reset", "puf_ch", puf_ch, 0);
        chk("reset", "resp_unst", {resp_word, unstable_cnt}, 0);
        chk("reset", "leds", {led1, led2}, 2'b10);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            set_w(vecs[i].mode, vecs[i].seed);
            run_check($sformatf("vec%0d", i), vecs[i].seed, vecs[i].spam, vecs[i].exp_lat);
        end
        for (int i = 0; i < 4; i++) begin
            set_w(2, 8'h00);
            run_check($sformatf("rand%0d", i), 8'($urandom), 1'($urandom), 576);
        end

        set_w(0, 8'h00);
        @(negedge clk);
        seed = 8'h10; base = clr_tot; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (111) @(negedge clk);
        chk("midrst", "in_settle", {puf_clr, puf_launch, puf_ch}, {2'b01, 8'h13});
        d0 = done_tot;
        rst = 1'b0;
        #1;
        chk("midrst", "outs_cleared", {busy, done, puf_launch, puf_clr}, 0);
        chk("midrst", "regs_cleared", {puf_ch, resp_word, unstable_cnt, led1, led2}, 31'h2);
        @(negedge clk);
        rst = 1'b1;
        repeat (700) @(negedge clk);
        chk("midrst", "no_done", done_tot - d0, 0);
        run_check("after_rst", 8'h10, 1'b0, 576);

        for (int k = 0; k < 4; k++) er2[k] = ^(8'(8'h7E + k));
        @(negedge clk);
        seed2 = 8'h7E; start2 = 1'b1; c0 = clr2_tot; l0 = launch2_tot;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("small", "latency", n, 20);
        chk("small", "resp_word", resp_word2, er2);
        chk("small", "unstable", unstable_cnt2, 0);
        chk("small", "leds", {led1_2, led2_2}, {!er2[3], er2[3]});
        chk("small", "clr_pulses", clr2_tot - c0, 4);
        chk("small", "launch_cycles", launch2_tot - l0, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
